traffic_light_ctrl: RTL
=======================

// Module: traffic_light_ctrl
// PURPOSE
//  Phase sequencer for a two-way (main/side) intersection. Steps through green, yellow and
//  all-red phases on a 1 Hz tick derived from the system clock, with a night flash mode.
//  Drives both signal heads and a 6-bit remaining-seconds count.
//  The count feeds the two-digit seven-segment display block.
// PARAMETERS
//  TICK_DIV       50_000_000  clk cycles per 1 s tick (>=2)
//  MAIN_GREEN_S   30          main green duration, s (1..59)
//  MAIN_YELLOW_S  3           main yellow duration, s (1..59)
//  SIDE_GREEN_S   20          side green duration, s (1..59)
//  SIDE_YELLOW_S  3           side yellow duration, s (1..59)
//  ALL_RED_S      2           all-red clearance duration, s (1..59)
// PORTS
//  clk         in   1  system clock, single domain
//  rst         in   1  synchronous reset, active-high
//  night_mode  in   1  level; 1 = flashing yellow on both heads; synchronous to clk
//  main_light  out  3  {red,yellow,green}, one-hot or 000 (night off-phase)
//  side_light  out  3  {red,yellow,green}
//  count       out  6  remaining seconds of current phase, to display input
//  phase       out  3  current state encoding (debug/status)
// BEHAVIOUR
//  - Clocking: one clock, clk. Reset is synchronous and active-high, on rst.
//  - Reset: state=MG, count=MAIN_GREEN_S, prescaler=0, flash=1.
//    Reset drives main_light=001 and side_light=100. Reset mid-phase aborts immediately.
//  - Prescaler: counts 0..TICK_DIV-1 and wraps; tick=1 for one cycle when value==TICK_DIV-1.
//    It free-runs and is cleared only by rst, never by mode changes.
//  - States and sequence: MG -> MY -> ARS -> SG -> SY -> ARM -> MG ...
//    Lights per state (main/side):
//      MG  = G/R
//      MY  = Y/R
//      ARS = R/R
//      SG  = R/G
//      SY  = R/Y
//      ARM = R/R
//  - On tick, normal states:
//    - count>1: count decrements by 1.
//    - count==1: advance to the next state and load that state's duration into count.
//    - Count never shows 0 in normal states. A phase of N s lasts exactly N*TICK_DIV cycles.
//  - NIGHT:
//    - Entry: night_mode==1 in any state moves to NIGHT on the next clk edge, without
//      waiting for a tick. Entry sets count=0 and flash=1.
//    - In NIGHT, flash toggles on each tick. Both heads show 010 when flash=1, 000 when flash=0.
//    - Exit: night_mode==0 in NIGHT moves to ARM with count=ALL_RED_S, then continues to MG.
//  - Simultaneous events:
//    - rst beats everything.
//    - night_mode=1 beats tick and count==1 advance.
//    - A tick in the exit cycle from NIGHT is ignored; ARM starts a full ALL_RED_S.
//  - Outputs: state, count and flash are registered. Lights and phase decode combinationally
//    from the registered state, so they change in the same cycle the state register updates.
//    count is always in 0..59.
//  - Safety invariant: never green or yellow on both heads at once, except the night flash
//    (yellow on both).
// STRUCTURE
//  - Shared package traffic_pkg holds:
//    - state encodings: MG=0, MY=1, ARS=2, SG=3, SY=4, ARM=5, NIGHT=6
//    - light constants: L_RED=3'b100, L_YEL=3'b010, L_GRN=3'b001, L_OFF=3'b000
//  - Sub-module tick_gen (parameter TICK_DIV; ports clk, rst, tick) implements the prescaler.
//  - The FSM, duration mux and count register live in traffic_light_ctrl.
// TESTING  (bench uses TICK_DIV=4, MG=5, MY=2, SG=3, SY=2, AR=1)
//  1. Release rst -> main=001, side=100, count=5.
//     Count steps 5,4,3,2,1, one step every 4 clk. Then MY with count=2.
//  2. Run one full cycle -> state order MG,MY,ARS,SG,SY,ARM,MG.
//     Cycle totals (5+2+1+3+2+1)*4 = 56 clk. No cycle has both heads non-red.
//  3. Assert night_mode during SG with count=2 -> next edge gives main=side=010, count=0.
//     After 4 clk both heads are 000; after 8 clk both are 010.
//  4. Deassert night_mode -> ARM (both 100, count=1) for one tick, then MG with count=5.
//  5. Assert night_mode in the same cycle as tick with count==1 in MY -> NIGHT, not ARS.
//  6. Assert rst for 1 cycle mid-SY -> next edge gives MG, count=5, main=001.
//     The prescaler restarts, so the first decrement comes 4 clk later.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase sequencer: state codes, lamp patterns
// and small decode helpers used by the controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    MG    = 3'd0,
    MY    = 3'd1,
    ARS   = 3'd2,
    SG    = 3'd3,
    SY    = 3'd4,
    ARM   = 3'd5,
    NIGHT = 3'd6
  } state_e;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  localparam int COUNT_W = 6;

  typedef struct packed {
    logic [2:0] main_head;
    logic [2:0] side_head;
  } heads_t;

  // Normal-cycle successor; NIGHT and the unused code fall back into the cycle at ARM
  // so the side head always gets a clearance interval before main goes green.
  function automatic state_e next_phase(input state_e s);
    state_e n;
    case (s)
      MG:      n = MY;
      MY:      n = ARS;
      ARS:     n = SG;
      SG:      n = SY;
      SY:      n = ARM;
      ARM:     n = MG;
      default: n = ARM;
    endcase
    return n;
  endfunction

  function automatic heads_t decode_heads(input state_e s, input logic flash);
    heads_t h;
    h.main_head = L_RED;
    h.side_head = L_RED;
    case (s)
      MG:    h.main_head = L_GRN;
      MY:    h.main_head = L_YEL;
      SG:    h.side_head = L_GRN;
      SY:    h.side_head = L_YEL;
      NIGHT: begin
        h.main_head = flash ? L_YEL : L_OFF;
        h.side_head = flash ? L_YEL : L_OFF;
      end
      default: ;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Only reset clears it, so mode changes never shift the one-second grid.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection phase sequencer with night flash mode; drives both signal heads,
// the remaining-seconds count for the display and a debug phase code.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int MAIN_GREEN_S  = 30,
  parameter int MAIN_YELLOW_S = 3,
  parameter int SIDE_GREEN_S  = 20,
  parameter int SIDE_YELLOW_S = 3,
  parameter int ALL_RED_S     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         night_mode,
  output logic [2:0]   main_light,
  output logic [2:0]   side_light,
  output logic [5:0]   count,
  output logic [2:0]   phase
);

  localparam logic [COUNT_W-1:0] DUR_MG  = COUNT_W'(MAIN_GREEN_S);
  localparam logic [COUNT_W-1:0] DUR_MY  = COUNT_W'(MAIN_YELLOW_S);
  localparam logic [COUNT_W-1:0] DUR_SG  = COUNT_W'(SIDE_GREEN_S);
  localparam logic [COUNT_W-1:0] DUR_SY  = COUNT_W'(SIDE_YELLOW_S);
  localparam logic [COUNT_W-1:0] DUR_AR  = COUNT_W'(ALL_RED_S);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 flash_q, flash_d;
  logic                 tick;
  heads_t               heads;

  function automatic logic [COUNT_W-1:0] duration(input state_e s);
    logic [COUNT_W-1:0] d;
    case (s)
      MG:      d = DUR_MG;
      MY:      d = DUR_MY;
      SG:      d = DUR_SG;
      SY:      d = DUR_SY;
      ARS,
      ARM:     d = DUR_AR;
      default: d = '0;
    endcase
    return d;
  endfunction

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Priority: night entry beats any tick/advance; while flashing, a night exit wins over
  // the tick so the clearance phase always starts with its full duration.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    flash_d = flash_q;
    if (night_mode && (state_q != NIGHT)) begin
      state_d = NIGHT;
      count_d = '0;
      flash_d = 1'b1;
    end else if (state_q == NIGHT) begin
      if (!night_mode) begin
        state_d = ARM;
        count_d = DUR_AR;
      end else if (tick) begin
        flash_d = ~flash_q;
      end
    end else if (tick) begin
      if (count_q > COUNT_W'(1)) begin
        count_d = count_q - COUNT_W'(1);
      end else begin
        state_d = next_phase(state_q);
        count_d = duration(next_phase(state_q));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MG;
      count_q <= DUR_MG;
      flash_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flash_q <= flash_d;
    end
  end

  assign heads      = decode_heads(state_q, flash_q);
  assign main_light = heads.main_head;
  assign side_light = heads.side_head;
  assign count      = count_q;
  assign phase      = state_q;

endmodule
